// File: rtl/rs_dec_syndrome_calc_par.sv
// rtl/rs_dec_syndrome_calc_par.sv - parallel GF(256) Reed-Solomon syndrome calculator
//
// Ports:
//   i_clk, i_res        clock; asynchronous active-high reset
//   i_frame_sync        pulse marking the start of a codeword
//   i_data/i_data_valid received symbol stream, highest-degree coefficient first
//   o_syn               N_PAR syndromes, S_j on bits [8j+7:8j]
//   o_valid             one-cycle pulse when o_syn holds a newly completed codeword
//   o_err               OR of all syndrome bits, updated with o_syn
//   o_frame_err         one-cycle pulse when a sync truncates a partial codeword
//   o_cnt               symbols accepted in the current codeword
module rs_dec_syndrome_calc_par #(
    parameter int N_SYM = 32,
    parameter int N_PAR = 4,
    parameter int FCR   = 0
) (
    input  logic                       i_clk,
    input  logic                       i_res,
    input  logic                       i_frame_sync,
    input  logic [7:0]                 i_data,
    input  logic                       i_data_valid,
    output logic [8*N_PAR-1:0]         o_syn,
    output logic                       o_valid,
    output logic                       o_err,
    output logic                       o_frame_err,
    output logic [$clog2(N_SYM)-1:0]   o_cnt
);

    localparam int CW = $clog2(N_SYM);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_SYM - 1);

    // GF(256) multiply modulo x^8+x^4+x^3+x^2+1 (0x11D). With one operand a
    // constant this folds to a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // alpha^e, evaluated only at elaboration to build the root constants.
    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < (e % 255); i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    logic [8*N_PAR-1:0] acc;
    logic [8*N_PAR-1:0] horner;
    logic [CW-1:0]      cnt;

    for (genvar j = 0; j < N_PAR; j++) begin : g_root
        localparam logic [7:0] ROOT = alpha_pow(FCR + j);
        assign horner[8*j +: 8] = gf_mul(acc[8*j +: 8], ROOT) ^ i_data;
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            acc         <= '0;
            cnt         <= '0;
            o_syn       <= '0;
            o_err       <= 1'b0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (i_frame_sync) begin
                // Sync takes priority, even over a last-symbol strobe: the
                // pending codeword is dropped and the coincident symbol (if
                // any) becomes symbol 0 of the new one.
                o_frame_err <= (cnt != '0);
                if (i_data_valid) begin
                    acc <= {N_PAR{i_data}};
                    cnt <= CW'(1);
                end else begin
                    acc <= '0;
                    cnt <= '0;
                end
            end else if (i_data_valid) begin
                if (cnt == CNT_LAST) begin
                    o_syn   <= horner;
                    o_err   <= |horner;
                    o_valid <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= horner;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign o_cnt = cnt;

endmodule

// File: tb/tb_rs_dec_syndrome_calc_par.sv
// tb/tb_rs_dec_syndrome_calc_par.sv - scoreboard bench for rs_dec_syndrome_calc_par
module tb_rs_dec_syndrome_calc_par;

    typedef struct packed {
        logic [31:0] syn;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sync;
    logic [1:0]  dv;
    logic [7:0]  din [2];
    logic [31:0] syn [2];
    logic [1:0]  vld;
    logic [1:0]  err;
    logic [1:0]  ferr;
    logic [4:0]  cnt [2];
    logic [31:0] cyc = 0;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q  [2][$];
    int   fq [2][$];

    // DUT 0: C1 RS(32,28), FCR=0.  DUT 1: C2 RS(28,24), FCR=1.
    rs_dec_syndrome_calc_par #(.N_SYM(32), .N_PAR(4), .FCR(0)) u_dut0 (
        .i_clk(clk), .i_res(rst), .i_frame_sync(sync[0]), .i_data(din[0]),
        .i_data_valid(dv[0]), .o_syn(syn[0]), .o_valid(vld[0]), .o_err(err[0]),
        .o_frame_err(ferr[0]), .o_cnt(cnt[0])
    );

    rs_dec_syndrome_calc_par #(.N_SYM(28), .N_PAR(4), .FCR(1)) u_dut1 (
        .i_clk(clk), .i_res(rst), .i_frame_sync(sync[1]), .i_data(din[1]),
        .i_data_valid(dv[1]), .o_syn(syn[1]), .o_valid(vld[1]), .o_err(err[1]),
        .o_frame_err(ferr[1]), .o_cnt(cnt[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Monitors: pop expectations whenever a DUT pulses, and check that the
    // syndrome outputs hold their last completed value between pulses.
    for (genvar g = 0; g < 2; g++) begin : mon
        exp_t        e;
        int          f;
        logic [31:0] hold = 0;
        always @(negedge clk) begin
            if (rst) begin
                hold = 0;
            end else begin
                if (vld[g]) begin
                    if (q[g].size() == 0) begin
                        chk($sformatf("dut%0d_unexpected_valid", g), 32'(vld[g]), 32'd0);
                    end else begin
                        e = q[g].pop_front();
                        chk($sformatf("dut%0d_valid_cycle", g), cyc, e.due);
                        chk($sformatf("dut%0d_syn", g), syn[g], e.syn);
                        chk($sformatf("dut%0d_err", g), 32'(err[g]), 32'(|e.syn));
                        hold = e.syn;
                    end
                end else begin
                    chk($sformatf("dut%0d_syn_hold", g), syn[g], hold);
                    chk($sformatf("dut%0d_err_hold", g), 32'(err[g]), 32'(|hold));
                end
                if (ferr[g]) begin
                    if (fq[g].size() == 0) begin
                        chk($sformatf("dut%0d_unexpected_frame_err", g), 32'(ferr[g]), 32'd0);
                    end else begin
                        f = fq[g].pop_front();
                        chk($sformatf("dut%0d_frame_err_cycle", g), cyc, 32'(f));
                    end
                end
            end
        end
    end

    task automatic drive(input int g, input bit s, input bit v, input logic [7:0] d);
        @(negedge clk);
        sync   = 2'b00;
        dv     = 2'b00;
        din[0] = 8'($urandom);
        din[1] = 8'($urandom);
        sync[g] = s;
        dv[g]   = v;
        din[g]  = d;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 8'($urandom));
    endtask

    // Symbols first..n-1 of a codeword; symbol pos carries val, others zero.
    task automatic codeword(input int g, input int n, input int first, input int pos,
                            input logic [7:0] val, input bit s, input bit gaps,
                            input logic [31:0] exp);
        for (int i = first; i < n; i++) begin
            if (gaps && (i % 3 == 1)) drive(g, 1'b0, 1'b0, 8'($urandom));
            drive(g, s && (i == first), 1'b1, (i == pos) ? val : 8'h00);
        end
        q[g].push_back('{syn: exp, due: cyc + 1});
    endtask

    task automatic partial(input int g, input int count, input logic [7:0] val, input bit s);
        for (int i = 0; i < count; i++) drive(g, s && (i == 0), 1'b1, val);
    endtask

    task automatic sync_restart(input logic [7:0] d);
        drive(0, 1'b1, 1'b1, d);
        fq[0].push_back(cyc + 1);
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_dut%0d_syn", tag, g), syn[g], 32'd0);
            chk($sformatf("%s_dut%0d_valid", tag, g), 32'(vld[g]), 32'd0);
            chk($sformatf("%s_dut%0d_err", tag, g), 32'(err[g]), 32'd0);
            chk($sformatf("%s_dut%0d_frame_err", tag, g), 32'(ferr[g]), 32'd0);
            chk($sformatf("%s_dut%0d_cnt", tag, g), 32'(cnt[g]), 32'd0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        sync   = 2'b00;
        dv     = 2'b00;
        din[0] = 8'h00;
        din[1] = 8'h00;
        #1;
        chk_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // All-zero codeword; counter returns to zero.
        codeword(0, 32, 0, -1, 8'h00, 1'b1, 1'b0, 32'h00000000);
        idle();
        chk("t1_cnt_after", 32'(cnt[0]), 32'd0);

        // 0x05 at degree 1: S_j = 5*alpha^j.
        codeword(0, 32, 0, 30, 8'h05, 1'b1, 1'b0, 32'h28140A05);
        // 0x01 at degree 31: S_j = alpha^(31j).
        codeword(0, 32, 0, 0, 8'h01, 1'b1, 1'b0, 32'hB6DEC001);
        // RS(28,24), FCR=1: degree 0 gives all ones; 0x05 at degree 1 gives 5*alpha^(j+1).
        codeword(1, 28, 0, 27, 8'h01, 1'b1, 1'b0, 32'h01010101);
        codeword(1, 28, 0, 26, 8'h05, 1'b1, 1'b0, 32'h5028140A);

        // Short frame: 10 symbols, then sync with a coincident 0x05.
        partial(0, 10, 8'h33, 1'b1);
        sync_restart(8'h05);
        idle();
        chk("t4_cnt_after_restart", 32'(cnt[0]), 32'd1);
        codeword(0, 32, 1, -1, 8'h00, 1'b0, 1'b0, 32'h5481E705);

        // Sync coincident with what would have been the last symbol.
        partial(0, 31, 8'h44, 1'b1);
        sync_restart(8'h05);
        codeword(0, 32, 1, -1, 8'h00, 1'b0, 1'b0, 32'h5481E705);

        // Back-to-back codewords with no sync, then one with strobe gaps.
        codeword(0, 32, 0, 30, 8'h05, 1'b1, 1'b0, 32'h28140A05);
        codeword(0, 32, 0, 0, 8'h01, 1'b0, 1'b0, 32'hB6DEC001);
        codeword(0, 32, 0, 0, 8'h01, 1'b0, 1'b1, 32'hB6DEC001);

        // Asynchronous reset mid-codeword.
        partial(0, 17, 8'h5A, 1'b1);
        idle();
        chk("t6_cnt_before_reset", 32'(cnt[0]), 32'd17);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        codeword(0, 32, 0, 30, 8'h05, 1'b1, 1'b0, 32'h28140A05);

        repeat (4) idle();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("dut%0d_missing_valid", g), 32'(q[g].size()), 32'd0);
            chk($sformatf("dut%0d_missing_frame_err", g), 32'(fq[g].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_dec_syndrome_calc_par.md
Name: rs_dec_syndrome_calc_par

Overview:
Parametrised syndrome calculator for the Reed-Solomon decoders in the CD data path. It serves C1 RS(32,28) and C2 RS(28,24), and any RS(N,K) over GF(256) with primitive polynomial 0x11D.
- Accepts one received symbol per strobe and evaluates N_PAR syndromes by Horner's rule.
- Tracks codeword boundaries and flags short frames.
- Presents double-buffered syndromes, so the next codeword can stream in with no gap.
- Sits between the deinterleaver and the error locator/evaluator stage.

Parameters:
N_SYM, 32, codeword length in symbols (legal 2..255)
N_PAR, 4, number of syndromes = parity symbols (legal 1..16)
FCR, 0, exponent of first consecutive root; syndrome j uses root alpha^(FCR+j) (legal 0..254)

Ports:
i_clk  in  1  clock
i_res  in  1  reset, asynchronous, active-high
i_frame_sync  in  1  single-cycle pulse: next accepted symbol (or the coincident one) is the first of a codeword
i_data  in  8  received symbol, highest-degree coefficient first
i_data_valid  in  1  single-cycle-per-symbol strobe, synchronous to i_clk; may be high every cycle
o_syn  out  8*N_PAR  syndromes; S_j on bits [8j+7:8j]
o_valid  out  1  one-cycle pulse: o_syn just updated with a completed codeword
o_err  out  1  OR of all bits of o_syn (any syndrome nonzero); updated with o_syn
o_frame_err  out  1  one-cycle pulse: frame sync arrived with a partial codeword pending
o_cnt  out  $clog2(N_SYM)  symbols accepted in current codeword (debug/observability)

Behaviour:
- Reset (i_res high, async):
  - accumulators, o_syn, o_cnt = 0
  - o_valid, o_err, o_frame_err = 0
  - reset mid-codeword discards the partial codeword; no pulse is produced.
- Root constants:
  - r_j = alpha^(FCR+j), alpha = 0x02 modulo 0x11D.
  - Computed at elaboration by a constant function, not by runtime logic.
  - Multipliers are constant-coefficient GF(256) multipliers.
- Horner update on an accepted symbol d (i_data_valid=1): acc_j <= gf_mul(acc_j, r_j) XOR d, for all j in parallel.
- Counter:
  - o_cnt increments per accepted symbol.
  - Last symbol is when o_cnt == N_SYM-1 and i_data_valid=1.
- Completion, on the last-symbol cycle:
  - Output regs load the Horner result including d.
  - Accumulators and o_cnt clear to 0.
  - o_valid=1 for exactly the following cycle (registered, latency 1 clock from last strobe).
  - o_err is updated on the same edge as o_syn.
- o_syn and o_err hold until the next completion. There is no backpressure; the consumer must capture on o_valid.
- Auto-wrap: with no i_frame_sync, symbol N_SYM+1 starts the next codeword, so continuous streams need no sync.
- i_frame_sync with o_cnt == 0: no effect other than alignment.
- i_frame_sync with o_cnt != 0:
  - accumulators and counter clear
  - o_frame_err pulses 1 cycle
  - no o_valid; o_syn keeps its previous value.
- i_frame_sync and i_data_valid in the same cycle:
  - the restart happens first
  - i_data becomes symbol 0 of the new codeword (acc_j <= d, o_cnt <= 1).
- i_frame_sync coincident with a last-symbol strobe: the sync restart wins. Codeword truncated → o_frame_err, no o_valid, acc <= d, o_cnt <= 1.
- i_data is ignored when i_data_valid=0; accumulators hold.

Test Plan:
1. Default params, 32 strobes of 0x00 back-to-back after sync → o_valid one cycle after 32nd strobe, o_syn=0x00000000, o_err=0, o_cnt back to 0.
2. Codeword all 0x00 except symbol 30 (degree 1) = 0x05 → S0=0x05, S1=0x0A, S2=0x14, S3=0x28, o_err=1.
3. Codeword all 0x00 except symbol 0 (degree 31) = 0x01 → S0=0x01, S1=0xC0 (alpha^31), o_err=1. Repeat with N_SYM=28, FCR=1, N_PAR=4, symbol 27 = 0x01 → all S_j=0x01.
4. Sync, 10 symbols, sync again with coincident 0x05, then 31 zeros:
   - o_frame_err pulses once after the second sync
   - no o_valid for the short frame
   - then o_valid with the syndromes of 0x05 at degree 31.
5. Two codewords streamed with i_data_valid high every cycle and no second sync → o_valid at cycles 33 and 65. o_syn from the first codeword stays stable until the second pulse. Include gaps in i_data_valid on a third codeword → identical syndromes.
6. Assert i_res asynchronously (between clock edges) mid-codeword at o_cnt=17 → all outputs 0 immediately. After release, a full codeword from test 2 yields the exact test 2 syndromes.
